// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter sharing one 5-to-1 datapath mux among five valid/ready
// requesters, with packet locking and a single-entry registered output stage.
module mux5_rr_arbiter #(
  parameter int size   = 32,
  parameter int NUM_IN = 5
) (
  input  logic                   CGRA_Clock,
  input  logic                   CGRA_Reset_n,
  input  logic [NUM_IN-1:0]      in_valid,
  input  logic [NUM_IN-1:0]      in_last,
  input  logic [NUM_IN*size-1:0] in_data,
  output logic [NUM_IN-1:0]      in_ready,
  output logic [2:0]             mux_select,
  output logic                   out_valid,
  output logic [size-1:0]        out_data,
  output logic [2:0]             out_src,
  output logic                   out_last,
  input  logic                   out_ready
);

  logic            lock;
  logic [2:0]      lock_idx;
  logic [2:0]      ptr;
  logic [2:0]      grant;
  logic            grant_valid;
  logic [2:0]      cand;
  logic            free;
  logic            accept;
  logic [size-1:0] mux_out;

  assign free = !out_valid || out_ready;

  // Locked packets keep their source; otherwise search ptr+1, ptr+2, ... modulo 5.
  always_comb begin
    grant       = 3'd0;
    grant_valid = 1'b0;
    cand        = 3'd0;
    if (lock) begin
      grant       = lock_idx;
      grant_valid = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        if (ptr >= 3'(NUM_IN - k)) cand = ptr - 3'(NUM_IN - k);
        else                       cand = ptr + 3'(k);
        if (!grant_valid && in_valid[cand]) begin
          grant       = cand;
          grant_valid = 1'b1;
        end
      end
    end
    if (!CGRA_Reset_n) grant_valid = 1'b0;
  end

  assign mux_select = grant_valid ? grant : 3'd7;

  always_comb begin
    case (mux_select)
      3'd0:    mux_out = in_data[0*size +: size];
      3'd1:    mux_out = in_data[1*size +: size];
      3'd2:    mux_out = in_data[2*size +: size];
      3'd3:    mux_out = in_data[3*size +: size];
      3'd4:    mux_out = in_data[4*size +: size];
      default: mux_out = '0;
    endcase
  end

  always_comb begin
    in_ready = '0;
    accept   = 1'b0;
    if (grant_valid && free) begin
      in_ready[grant] = in_valid[grant];
      accept          = in_valid[grant];
    end
  end

  // An accept loads the output stage and updates lock/priority; otherwise a drain empties it.
  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
    if (!CGRA_Reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 3'd0;
      out_last  <= 1'b0;
      lock      <= 1'b0;
      lock_idx  <= 3'd0;
      ptr       <= 3'd4;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
      out_src   <= grant;
      out_last  <= in_last[grant];
      if (in_last[grant]) begin
        lock <= 1'b0;
        ptr  <= grant;
      end else begin
        lock     <= 1'b1;
        lock_idx <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed bench for mux5_rr_arbiter: a vector table walked cycle by cycle,
// plus hand-written reset sequences.
module tb_mux5_rr_arbiter;

  localparam logic [31:0] D0 = 32'hC0DE_0000;
  localparam logic [31:0] D1 = 32'hC0DE_0001;
  localparam logic [31:0] D2 = 32'hC0DE_0002;
  localparam logic [31:0] D3 = 32'hC0DE_0003;
  localparam logic [31:0] D4 = 32'hC0DE_0004;

  logic         clock;
  logic         resetN;
  logic [4:0]   inValid;
  logic [4:0]   inLast;
  logic [159:0] inData;
  logic [4:0]   inReady;
  logic [2:0]   muxSelect;
  logic         outValid;
  logic [31:0]  outData;
  logic [2:0]   outSrc;
  logic         outLast;
  logic         outReady;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  valid;
    logic [4:0]  last;
    logic [31:0] w2;
    logic        rdy;
    logic [4:0]  expReady;
    logic [2:0]  expSel;
    logic        expOutValid;
    logic [2:0]  expSrc;
    logic [31:0] expData;
    logic        expLast;
  } vec_t;

  vec_t vecs[$];

  mux5_rr_arbiter #(.size(32), .NUM_IN(5)) dut (
    .CGRA_Clock   (clock),
    .CGRA_Reset_n (resetN),
    .in_valid     (inValid),
    .in_last      (inLast),
    .in_data      (inData),
    .in_ready     (inReady),
    .mux_select   (muxSelect),
    .out_valid    (outValid),
    .out_data     (outData),
    .out_src      (outSrc),
    .out_last     (outLast),
    .out_ready    (outReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mkVec(logic [4:0] valid, logic [4:0] last, logic [31:0] w2,
                                 logic rdy, logic [4:0] expReady, logic [2:0] expSel,
                                 logic expOutValid, logic [2:0] expSrc,
                                 logic [31:0] expData, logic expLast);
    vec_t v;
    v.valid = valid; v.last = last; v.w2 = w2; v.rdy = rdy;
    v.expReady = expReady; v.expSel = expSel; v.expOutValid = expOutValid;
    v.expSrc = expSrc; v.expData = expData; v.expLast = expLast;
    return v;
  endfunction

  task automatic checkField(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    inValid  = v.valid;
    inLast   = v.last;
    inData   = {D4, D3, v.w2, D1, D0};
    outReady = v.rdy;
  endtask

  task automatic checkOutput(int idx, vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    checkField({tag, ".in_ready"}, 32'(inReady), 32'(v.expReady));
    checkField({tag, ".mux_select"}, 32'(muxSelect), 32'(v.expSel));
    checkField({tag, ".out_valid"}, 32'(outValid), 32'(v.expOutValid));
    if (v.expOutValid) begin
      checkField({tag, ".out_src"}, 32'(outSrc), 32'(v.expSrc));
      checkField({tag, ".out_data"}, outData, v.expData);
      checkField({tag, ".out_last"}, 32'(outLast), 32'(v.expLast));
    end
  endtask

  initial begin
    // Rotation from reset: priority starts at 0 because ptr resets to 4.
    vecs.push_back(mkVec(5'b11111, 5'b11111, D2, 1, 5'b00001, 0, 0, 0, 0,  0));
    vecs.push_back(mkVec(5'b11111, 5'b11111, D2, 1, 5'b00010, 1, 1, 0, D0, 1));
    vecs.push_back(mkVec(5'b11111, 5'b11111, D2, 1, 5'b00100, 2, 1, 1, D1, 1));
    vecs.push_back(mkVec(5'b11111, 5'b11111, D2, 1, 5'b01000, 3, 1, 2, D2, 1));
    vecs.push_back(mkVec(5'b11111, 5'b11111, D2, 1, 5'b10000, 4, 1, 3, D3, 1));
    vecs.push_back(mkVec(5'b11111, 5'b11111, D2, 1, 5'b00001, 0, 1, 4, D4, 1));
    // Three-beat packet from 2 with 3 waiting, including a bubble while locked.
    vecs.push_back(mkVec(5'b01100, 5'b01000, 32'hA0, 1, 5'b00100, 2, 1, 0, D0, 1));
    vecs.push_back(mkVec(5'b01100, 5'b01000, 32'hA1, 1, 5'b00100, 2, 1, 2, 32'hA0, 0));
    vecs.push_back(mkVec(5'b01000, 5'b01000, D2,     1, 5'b00000, 2, 1, 2, 32'hA1, 0));
    vecs.push_back(mkVec(5'b01100, 5'b01100, 32'hA2, 1, 5'b00100, 2, 0, 0, 0,  0));
    vecs.push_back(mkVec(5'b01000, 5'b01000, D2,     1, 5'b01000, 3, 1, 2, 32'hA2, 1));
    // Backpressure for four cycles, then release with accept in the same cycle.
    vecs.push_back(mkVec(5'b00011, 5'b00011, D2, 0, 5'b00000, 0, 1, 3, D3, 1));
    vecs.push_back(mkVec(5'b00011, 5'b00011, D2, 0, 5'b00000, 0, 1, 3, D3, 1));
    vecs.push_back(mkVec(5'b00011, 5'b00011, D2, 0, 5'b00000, 0, 1, 3, D3, 1));
    vecs.push_back(mkVec(5'b00011, 5'b00011, D2, 0, 5'b00000, 0, 1, 3, D3, 1));
    vecs.push_back(mkVec(5'b00011, 5'b00011, D2, 1, 5'b00001, 0, 1, 3, D3, 1));
    vecs.push_back(mkVec(5'b00010, 5'b00010, D2, 1, 5'b00010, 1, 1, 0, D0, 1));
    // Idle and drain.
    vecs.push_back(mkVec(5'b00000, 5'b00000, D2, 1, 5'b00000, 7, 1, 1, D1, 1));
    vecs.push_back(mkVec(5'b00000, 5'b00000, D2, 1, 5'b00000, 7, 0, 0, 0,  0));
    // Wrap: after a last beat from 4, requester 0 beats requester 3.
    vecs.push_back(mkVec(5'b10000, 5'b10000, D2, 1, 5'b10000, 4, 0, 0, 0,  0));
    vecs.push_back(mkVec(5'b01001, 5'b01001, D2, 1, 5'b00001, 0, 1, 4, D4, 1));
    vecs.push_back(mkVec(5'b01000, 5'b01000, D2, 1, 5'b01000, 3, 1, 0, D0, 1));
    vecs.push_back(mkVec(5'b00000, 5'b00000, D2, 1, 5'b00000, 7, 1, 3, D3, 1));

    resetN = 1'b0;
    applyStimulus(mkVec(5'b11111, 5'b11111, D2, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clock);
    #1;
    checkField("reset.mux_select", 32'(muxSelect), 32'd7);
    checkField("reset.in_ready", 32'(inReady), 32'd0);
    checkField("reset.out_valid", 32'(outValid), 32'd0);
    checkField("reset.out_data", outData, 32'd0);
    checkField("reset.out_src", 32'(outSrc), 32'd0);
    checkField("reset.out_last", 32'(outLast), 32'd0);
    inValid = 5'b00000;
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;

    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n]);
      @(negedge clock);
      checkOutput(n, vecs[n]);
      @(posedge clock);
      #1;
    end

    // Async reset during beat 2 of a packet from requester 1 (ptr is 3 here).
    applyStimulus(mkVec(5'b00010, 5'b00000, D2, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    checkField("pkt1.beat1.in_ready", 32'(inReady), 32'b00010);
    checkField("pkt1.beat1.mux_select", 32'(muxSelect), 32'd1);
    @(posedge clock);
    #2;
    checkField("pkt1.beat2.out_valid", 32'(outValid), 32'd1);
    checkField("pkt1.beat2.out_data", outData, D1);
    resetN = 1'b0;
    #1;
    checkField("arst.out_valid", 32'(outValid), 32'd0);
    checkField("arst.out_data", outData, 32'd0);
    checkField("arst.mux_select", 32'(muxSelect), 32'd7);
    checkField("arst.in_ready", 32'(inReady), 32'd0);
    applyStimulus(mkVec(5'b10000, 5'b10000, D2, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    #1;
    checkField("post.mux_select", 32'(muxSelect), 32'd4);
    checkField("post.in_ready", 32'(inReady), 32'b10000);
    @(posedge clock);
    #1;
    checkField("post.out_valid", 32'(outValid), 32'd1);
    checkField("post.out_src", 32'(outSrc), 32'd4);
    checkField("post.out_data", outData, D4);
    checkField("post.out_last", 32'(outLast), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux5_rr_arbiter.md
Name: mux5_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 5-to-1 32-bit datapath mux among five valid/ready requesters. It drives the mux select from the current grant, holds the grant for multi-beat transfers, and registers the selected word into a single-entry output stage with a valid/ready handshake. It sits between CGRA functional-unit output ports and a shared routing resource such as a memory port or bus segment.

Parameters:
size, 32, data width of each input and of the output
NUM_IN, 5, number of requesters; fixed at 5 to match the 3-bit mux select

Ports:
CGRA_Clock  input  1  sole clock; all state updates on the rising edge
CGRA_Reset_n  input  1  asynchronous, active-low reset
in_valid  input  5  per-requester valid; bit i belongs to requester i
in_last  input  5  per-requester last-beat flag; sampled only with in_valid
in_data  input  5*size  requester i data at bits [i*size +: size]
in_ready  output  5  per-requester ready; at most one bit high
mux_select  output  3  select driven to the shared 5-to-1 mux; 0-4 = source, 7 = idle
out_valid  output  1  output register holds a word
out_data  output  size  registered mux output
out_src  output  3  index of the source of out_data
out_last  output  1  registered in_last of that beat
out_ready  input  1  downstream accepts out_data this cycle

Behaviour:
- Reset: async assert forces out_valid=0, out_data=0, out_src=0, out_last=0, lock=0, ptr=4. in_ready=0 and mux_select=7 while reset is held. Deassertion mid-transfer abandons the transfer; no partial state survives.
- Slot free: free = !out_valid || out_ready (combinational).
- Grant, combinational:
  - If lock=1, grant = locked index.
  - Otherwise, grant = first i with in_valid[i]=1, searching ptr+1, ptr+2, ... modulo 5.
  - With no valid request, there is no grant.
- mux_select = grant index when a grant exists, else 7. The mux outputs zero for select 5-7.
- in_ready[grant] = free && in_valid[grant]. All other in_ready bits are 0. in_ready never depends on out_valid alone; it is gated only by free.
- Accept: a beat transfers when in_valid[g] && in_ready[g]. On the next edge:
  - out_data = mux output (in_data of g).
  - out_src = g, out_last = in_last[g], out_valid = 1.
- Latency: 1 cycle from accept to out_valid. With out_ready held at 1, throughput is one beat per cycle.
- Output drain: if out_valid && out_ready and there is no accept that cycle, out_valid clears to 0. Accept and drain in the same cycle leave out_valid=1 with the new word.
- Stall: while out_valid && !out_ready, out_* hold and all in_ready are 0.
- Lock/packet rules:
  - On accept with in_last[g]=0: lock=1 and the locked index = g.
  - On accept with in_last[g]=1: lock=0 and ptr=g.
  - While locked, other requesters are ignored even if g drops in_valid (bubbles allowed).
- ptr changes only on a last-beat accept. A single-beat transfer (last=1) therefore rotates priority immediately.
- Any valid input must not influence in_ready unless it is the granted source. Requesters may deassert in_valid without acceptance only while unlocked.
- No combinational path from out_ready to out_data. A path from out_ready to in_ready is permitted.

Test Plan:
1. Reset priority: after reset, in_valid=5'b11111 with all in_last=1 and out_ready=1. Accepts must occur in the order 0,1,2,3,4,0. out_src follows each accept by 1 cycle. mux_select shows 0,1,2,3,4.
2. Packet lock: requester 2 sends 3 beats (last on beat 3, data 0xA0..0xA2) while requester 3 holds valid. Grant must stay on 2 for all 3 beats, then move to 3. out_data must read 0xA0, 0xA1, 0xA2, then requester 3's word.
3. Backpressure: out_valid=1 and out_ready=0 for 4 cycles. in_ready must be 00000, and out_data/out_src must stay stable. Raising out_ready gives an accept in that same cycle and new out_data on the next edge.
4. Idle: all in_valid=0. mux_select must be 7 and in_ready 00000. out_valid drops one cycle after the final drain.
5. Async reset mid-packet: assert CGRA_Reset_n low between clock edges during beat 2 of a 3-beat packet from requester 1. out_valid must go 0 immediately. After release, a request from 4 must be granted with no lock carried over.
6. Wrap: ptr=4 (after a requester-4 last beat) and requests from 3 and 0. Requester 0 must be granted first, then 3.
